// File: rtl/demux_sixteen_pkg.sv
// Shared constants and FSM state type for the sixteen-way write demultiplexer.
package demux_sixteen_pkg;

    localparam int unsigned DEST_COUNT = 16;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/demux_sixteen_dec4to16.sv
// Combinational 4-to-16 one-hot decoder producing per-destination write enables.
module dec4to16
    import demux_sixteen_pkg::*;
(
    input  logic [3:0]            sel,
    input  logic                  en,
    output logic [DEST_COUNT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_sixteen.sv
// Sixteen-destination registered write demux with a two-state accept/commit handshake.
// Optional macro DEMUX_SIXTEEN_ZERO0_EN pins outa to zero.
module demux_sixteen
    import demux_sixteen_pkg::*;
#(
    parameter int w = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [w-1:0]     in,
    input  logic [3:0]       sel,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic             wr_done,
    output logic [w-1:0]     outa,
    output logic [w-1:0]     outb,
    output logic [w-1:0]     outc,
    output logic [w-1:0]     outd,
    output logic [w-1:0]     oute,
    output logic [w-1:0]     outf,
    output logic [w-1:0]     outg,
    output logic [w-1:0]     outh,
    output logic [w-1:0]     outi,
    output logic [w-1:0]     outj,
    output logic [w-1:0]     outk,
    output logic [w-1:0]     outl,
    output logic [w-1:0]     outm,
    output logic [w-1:0]     outn,
    output logic [w-1:0]     outo,
    output logic [w-1:0]     outp,
    output logic [CNT_W-1:0] wr_cnt
);

`ifdef DEMUX_SIXTEEN_ZERO0_EN
    localparam logic [DEST_COUNT-1:0] WE_MASK = 16'hFFFE;
`else
    localparam logic [DEST_COUNT-1:0] WE_MASK = 16'hFFFF;
`endif

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic                  commit;
    logic [w-1:0]          hold_data;
    logic [3:0]            hold_sel;
    logic [w-1:0]          dest [DEST_COUNT];
    logic [DEST_COUNT-1:0] we_raw;
    logic [DEST_COUNT-1:0] we;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        wr_ready  = 1'b0;
        wr_done   = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    accept    = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_done   = 1'b1;
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    dec4to16 u_dec (
        .sel    (hold_sel),
        .en     (commit),
        .onehot (we_raw)
    );

    // The count still advances on a masked destination; only the data write is suppressed.
    assign we = we_raw & WE_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_sel  <= '0;
            wr_cnt    <= '0;
            for (int unsigned i = 0; i < DEST_COUNT; i++) begin
                dest[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                hold_data <= in;
                hold_sel  <= sel;
            end
            if (commit) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            for (int unsigned i = 0; i < DEST_COUNT; i++) begin
                if (we[i]) begin
                    dest[i] <= hold_data;
                end
            end
        end
    end

    assign outa = dest[0];
    assign outb = dest[1];
    assign outc = dest[2];
    assign outd = dest[3];
    assign oute = dest[4];
    assign outf = dest[5];
    assign outg = dest[6];
    assign outh = dest[7];
    assign outi = dest[8];
    assign outj = dest[9];
    assign outk = dest[10];
    assign outl = dest[11];
    assign outm = dest[12];
    assign outn = dest[13];
    assign outo = dest[14];
    assign outp = dest[15];

endmodule

// File: tb/tb_demux_sixteen.sv
// Self-checking bench for demux_sixteen: transaction-queue reference model plus directed literal checks.
module tb_demux_sixteen;

    logic        clk;
    logic        rst_n;
    logic [31:0] in;
    logic [3:0]  sel;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_done;
    logic [7:0]  wr_cnt;
    logic [31:0] dout [16];

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    bit          cmp_en    = 1'b0;

    demux_sixteen #(.w(32)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_done(wr_done),
        .outa(dout[0]),  .outb(dout[1]),  .outc(dout[2]),  .outd(dout[3]),
        .oute(dout[4]),  .outf(dout[5]),  .outg(dout[6]),  .outh(dout[7]),
        .outi(dout[8]),  .outj(dout[9]),  .outk(dout[10]), .outl(dout[11]),
        .outm(dout[12]), .outn(dout[13]), .outo(dout[14]), .outp(dout[15]),
        .wr_cnt(wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a pending-write queue; an accepted write lands one edge later.
    typedef struct {
        logic [3:0]  s;
        logic [31:0] d;
    } txn_t;

    txn_t        pend [$];
    logic [31:0] exp_out [16];
    int unsigned exp_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            for (int k = 0; k < 16; k++) exp_out[k] = 32'h0;
            exp_cnt = 0;
        end else if (pend.size() != 0) begin
            txn_t t;
            t = pend.pop_front();
`ifdef DEMUX_SIXTEEN_ZERO0_EN
            if (t.s != 4'd0) exp_out[t.s] = t.d;
`else
            exp_out[t.s] = t.d;
`endif
            exp_cnt = (exp_cnt + 1) % 256;
        end else if (wr_valid) begin
            txn_t t;
            t.s = sel;
            t.d = in;
            pend.push_back(t);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 16; k++) begin
                check($sformatf("model_out%0d", k), dout[k], exp_out[k]);
            end
            check("model_cnt",   {24'h0, wr_cnt},   exp_cnt);
            check("model_ready", {31'h0, wr_ready}, {31'h0, pend.size() == 0});
            check("model_done",  {31'h0, wr_done},  {31'h0, pend.size() != 0});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        rst_n    = 1'b0;
        edge1();
        edge1();
        rst_n = 1'b1;
    endtask

    task automatic write1(input logic [3:0] s, input logic [31:0] d);
        sel = s; in = d; wr_valid = 1'b1;
        edge1();
        wr_valid = 1'b0;
        edge1();
    endtask

    initial begin
        rst_n = 1'b1; wr_valid = 1'b0; sel = 4'd0; in = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        cmp_en = 1'b1;
        check("reset_ready", {31'h0, wr_ready}, 32'h1);
        check("reset_done",  {31'h0, wr_done},  32'h0);
        check("reset_cnt",   {24'h0, wr_cnt},   32'h0);
        check("reset_outf",  dout[5],           32'h0);
        edge1();
        // valid during reset must not be accepted
        wr_valid = 1'b1; sel = 4'd2; in = 32'h77;
        edge1();
        wr_valid = 1'b0;
        rst_n = 1'b1;
        edge1();
        check("no_accept_in_reset", dout[2], 32'h0);

        // single write sel=5
        sel = 4'd5; in = 32'hDEADBEEF; wr_valid = 1'b1;
        edge1();
        wr_valid = 1'b0;
        check("t1_done_hi",  {31'h0, wr_done},  32'h1);
        check("t1_ready_lo", {31'h0, wr_ready}, 32'h0);
        check("t1_outf_pre", dout[5],           32'h0);
        edge1();
        check("t1_outf",     dout[5],           32'hDEADBEEF);
        check("t1_done_lo",  {31'h0, wr_done},  32'h0);
        check("t1_cnt",      {24'h0, wr_cnt},   32'h1);
        check("t1_oute",     dout[4],           32'h0);

        // back-to-back valid, sel 0..15
        do_reset();
        wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel = 4'(i); in = 32'(i) * 32'h11;
            edge1();
            edge1();
        end
        wr_valid = 1'b0;
        check("t2_cnt",  {24'h0, wr_cnt}, 32'd16);
        check("t2_outp", dout[15],        32'hFF);
        check("t2_outc", dout[2],         32'h22);

        // in/sel change during WRITE is ignored
        sel = 4'd3; in = 32'hAAAA; wr_valid = 1'b1;
        edge1();
        sel = 4'd9; in = 32'h1;
        edge1();
        wr_valid = 1'b0;
        check("t3_outd", dout[3], 32'hAAAA);
        check("t3_outj", dout[9], 32'h99);
        check("t3_cnt",  {24'h0, wr_cnt}, 32'd17);

        // reset during WRITE discards the held write
        do_reset();
        sel = 4'd7; in = 32'h55; wr_valid = 1'b1;
        edge1();
        wr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t4_ready_async", {31'h0, wr_ready}, 32'h1);
        check("t4_done_async",  {31'h0, wr_done},  32'h0);
        check("t4_outh_async",  dout[7],           32'h0);
        #3 rst_n = 1'b1;
        edge1();
        check("t4_outh", dout[7],         32'h0);
        check("t4_cnt",  {24'h0, wr_cnt}, 32'h0);

        // 256 commits wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            write1(4'(i % 16), 32'(i));
        end
        check("t5_cnt_wrap", {24'h0, wr_cnt}, 32'h0);
        check("t5_outb",     dout[1],         32'd241);

        write1(4'd0, 32'h1234);
`ifdef DEMUX_SIXTEEN_ZERO0_EN
        check("t5_outa", dout[0], 32'h0);
`else
        check("t5_outa", dout[0], 32'h1234);
`endif
        check("t5_cnt_inc", {24'h0, wr_cnt}, 32'h1);

        edge1();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/demux_sixteen.md
DEMUX_SIXTEEN -- requirements
Module: demux_sixteen

Interface
REQ-001 SHALL have parameter w, default 32, data width of the input and of each of the 16 outputs.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in  input  w  write data.
REQ-005 SHALL have port sel  input  4  destination index; 0 selects outa and 15 selects outp.
REQ-006 SHALL have port wr_valid  input  1  write request.
REQ-007 SHALL have port wr_ready  output  1  block can accept a request.
REQ-008 SHALL have port wr_done  output  1  one-cycle pulse: held write is committed at the next edge.
REQ-009 SHALL have ports outa..outp  output  w each  registered contents of destinations 0..15.
REQ-010 SHALL have port wr_cnt  output  8  count of committed writes, wrapping.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and WRITE.
REQ-012 SHALL drive wr_ready=1 in IDLE and wr_ready=0 in WRITE, decoded from registered state only.
REQ-013 SHALL accept a request on a rising edge where wr_valid=1 and wr_ready=1: capture in and sel into holding registers, then go IDLE->WRITE.
REQ-014 SHALL drive wr_done=1 for exactly the one cycle spent in WRITE.
REQ-015 SHALL commit on the edge ending WRITE: write the held data into the destination given by held sel, increment wr_cnt, go WRITE->IDLE.
REQ-016 SHALL show the new value on the outputs one edge after acceptance plus one edge, so the commit edge is the 2nd edge counting the accept edge as the 1st.
REQ-017 SHALL leave all 15 non-selected outputs unchanged on every commit.
REQ-018 SHALL ignore wr_valid, in and sel while in WRITE, with no queuing.
REQ-019 SHALL sustain at most one accepted request per 2 cycles; back-to-back valid is accepted on alternate edges.
REQ-020 SHALL change in/sel after acceptance without affecting the committed data.
REQ-021 SHALL wrap wr_cnt from 255 to 0.

Reset
REQ-022 SHALL, when rst_n=0 and independent of clk, force: state IDLE; outa..outp=0; held data=0; held sel=0; wr_cnt=0; wr_done=0.
REQ-023 SHALL drive wr_ready=1 immediately on reset, since state is IDLE.
REQ-024 SHALL, if reset is asserted while in WRITE, discard the held write: no output update and no wr_cnt increment.
REQ-025 SHALL, after rst_n deasserts, accept its first request no earlier than the first clk edge with rst_n=1.

Configuration
REQ-026 SHALL, with macro DEMUX_SIXTEEN_ZERO0_EN defined, hold outa at 0 permanently; a commit to sel=0 still pulses wr_done and increments wr_cnt.
REQ-027 SHALL, without DEMUX_SIXTEEN_ZERO0_EN, treat outa as a normal writable destination.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, WRITE) and the constants DEST_COUNT=16 and CNT_W=8 in the shared processor package.
REQ-029 SHALL use a sub-module dec4to16: a combinational 4-to-16 one-hot decoder of held sel, gated by commit, that produces the per-destination write enables.
REQ-030 SHALL contain no other sub-modules.

Verification
REQ-031 SHALL cover: reset, then wr_valid=1, sel=5, in=0xDEADBEEF -> wr_done high for one cycle, outf=0xDEADBEEF at edge 2, all other outputs 0, wr_cnt=1.
REQ-032 SHALL cover: wr_valid held high with sel=0..15 incrementing and in=sel*0x11 -> writes accepted every 2nd edge, outX matches in order, wr_cnt=16.
REQ-033 SHALL cover: in/sel changed to sel=9, in=0x1 in the WRITE cycle after accepting sel=3, in=0xAAAA -> outd=0xAAAA, outj unchanged.
REQ-034 SHALL cover: rst_n pulsed low during WRITE with sel=7, in=0x55 -> outh=0, wr_cnt=0, wr_ready=1 asynchronously.
REQ-035 SHALL cover: 256 commits -> wr_cnt=0; with DEMUX_SIXTEEN_ZERO0_EN, a write of 0x1234 to sel=0 -> outa=0, wr_cnt increments.
